// File: rtl/bridge_utils_pkg.sv
// rtl/bridge_utils_pkg.sv - shared AXI2APB bridge types, encodings and burst address helper
package bridge_utils;

    localparam int BRIDGE_ADDR_W = 32;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [BRIDGE_ADDR_W-1:0] addr;
        logic [3:0]               len;
        logic [2:0]               size;
        logic [1:0]               burst;
    } addr_info_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_DONE
    } apb_rd_state_t;

    // WRAP keeps the bits above the (len+1)*inc window and wraps the rest.
    function automatic logic [BRIDGE_ADDR_W-1:0] next_addr(
        input logic [BRIDGE_ADDR_W-1:0] addr,
        input logic [3:0]               len,
        input logic [2:0]               size,
        input logic [1:0]               burst
    );
        logic [BRIDGE_ADDR_W-1:0] inc;
        logic [BRIDGE_ADDR_W-1:0] incr;
        logic [BRIDGE_ADDR_W-1:0] mask;
        inc  = BRIDGE_ADDR_W'(1) << size;
        incr = addr + inc;
        mask = ((BRIDGE_ADDR_W'(len) + BRIDGE_ADDR_W'(1)) * inc) - BRIDGE_ADDR_W'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
            default:     next_addr = incr;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO with occupancy count
module sync_fifo_fwft #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the output is defined straight out of reset.
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/apb_read_master.sv
// rtl/apb_read_master.sv - executes a latched AXI read burst as APB reads into a beat FIFO
module apb_read_master
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  addr_info_t                    addr_info,
    output logic                          busy,
    output logic                          done,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          psel,
    output logic                          penable,
    output logic                          pwrite,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr,
    input  logic                          fifo_read,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [1:0]                    fifo_resp,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    apb_rd_state_t           state_q, state_d;
    logic [3:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [3:0]              beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;

    logic                    push;
    logic                    fifo_full;
    logic                    full_after_push;
    logic [DATA_WIDTH+1:0]   fifo_dout;

    // A same-cycle pop frees the slot the push would otherwise fill.
    assign full_after_push = (fifo_count == CNT_W'(FIFO_DEPTH - 1)) && !(fifo_read && !fifo_empty);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        paddr_d = paddr_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = addr_info.len;
                    size_d  = addr_info.size;
                    burst_d = addr_info.burst;
                    beat_d  = 4'd0;
                    paddr_d = ADDR_WIDTH'(addr_info.addr);
                    // Beats left over from an undrained burst must not be overrun.
                    state_d = fifo_full ? ST_HOLD : ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    push = 1'b1;
                    if (beat_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        paddr_d = ADDR_WIDTH'(next_addr(BRIDGE_ADDR_W'(paddr_q), len_q, size_q, burst_q));
                        state_d = full_after_push ? ST_HOLD : ST_SETUP;
                    end
                end
            end
            ST_HOLD: begin
                if (!fifo_full) state_d = ST_SETUP;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            paddr_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            paddr_q <= paddr_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable = (state_q == ST_ACCESS);
    assign pwrite  = 1'b0;
    assign paddr   = paddr_q;

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (fifo_read),
        .din   ({prdata, (pslverr ? RESP_SLVERR : RESP_OKAY)}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign fifo_data = fifo_dout[DATA_WIDTH+1:2];
    assign fifo_resp = fifo_dout[1:0];

endmodule

// File: tb/tb_apb_read_master.sv
// tb/tb_apb_read_master.sv - self-checking bench for apb_read_master
module tb_apb_read_master;
    import bridge_utils::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    addr_info_t              addr_info = '0;
    logic                    busy, done, psel, penable, pwrite;
    logic [AW-1:0]           paddr;
    logic [DW-1:0]           prdata = '0;
    logic                    pready = 1'b0;
    logic                    pslverr = 1'b0;
    logic                    fifo_read = 1'b0;
    logic [DW-1:0]           fifo_data;
    logic [1:0]              fifo_resp;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;

    always #5 clk = ~clk;

    apb_read_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr_info  (addr_info),
        .busy       (busy),
        .done       (done),
        .paddr      (paddr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .fifo_resp  (fifo_resp),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count)
    );

    int checks = 0;
    int failures = 0;

    logic [DW+1:0] mq[$];
    logic [AW-1:0] obs_addr[$];
    logic [AW-1:0] exp_addr[16];
    int  waits[16];
    bit  errs[16];
    int  beats, beat_idx, acc_cycles, wait_total, psel_cycles, done_cnt;
    int  pop_pct;
    bit  pop_once, start_req, stray_en;
    bit  prev_setup, prev_wait;
    logic [AW-1:0] prev_paddr;

    typedef struct {
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [2:0]   size;
        logic [1:0]   burst;
        int           wait_beat;
        int           wait_n;
        int           err_beat;
        logic [127:0] exp_a;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_addr(input logic [31:0] a, input int len, input int size,
                                             input logic [1:0] b, input int i);
        longint unsigned inc, wb, base, av;
        av  = a;
        inc = 64'd1 << size;
        wb  = longint'(len + 1) * inc;
        case (b)
            2'b00:   return a;
            2'b10: begin
                base = av - (av % wb);
                return 32'(base + ((av - base + longint'(i) * inc) % wb));
            end
            default: return 32'(av + longint'(i) * inc);
        endcase
    endfunction

    task automatic step();
        logic [DW+1:0] ent;
        bit            complete;
        int            b;
        ent = '0;
        complete = 1'b0;
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("fifo_empty", 64'(fifo_empty), 64'(mq.size() == 0));
        if (mq.size() > 0) chk("fifo_head", 64'({fifo_data, fifo_resp}), 64'(mq[0]));
        if (mq.size() == DEPTH) chk("psel_when_full", 64'(psel), 64'(0));
        if (prev_setup) chk("setup_to_access", 64'({psel, penable}), 64'(2'b11));
        if (prev_setup || prev_wait) chk("paddr_stable", 64'(paddr), 64'(prev_paddr));
        chk("pwrite_low", 64'(pwrite), 64'(0));
        if (done) begin
            done_cnt++;
            chk("done_after_last", 64'(beat_idx), 64'(beats));
        end
        if (psel) psel_cycles++;

        pready  = 1'($urandom_range(1));
        prdata  = $urandom;
        pslverr = 1'($urandom_range(1));
        if (psel && penable) begin
            b = (beat_idx < 16) ? beat_idx : 15;
            if (acc_cycles >= waits[b]) begin
                complete = 1'b1;
                pready   = 1'b1;
                pslverr  = errs[b];
                chk("paddr_beat", 64'(paddr), 64'(exp_addr[b]));
                chk("beat_in_range", 64'(beat_idx < beats), 64'(1));
                chk("no_push_when_full", 64'(mq.size() < DEPTH), 64'(1));
                obs_addr.push_back(paddr);
                ent = {prdata, (pslverr ? RESP_SLVERR : RESP_OKAY)};
                beat_idx++;
                acc_cycles = 0;
            end else begin
                pready = 1'b0;
                acc_cycles++;
                wait_total++;
            end
        end
        prev_setup = psel && !penable;
        prev_wait  = psel && penable && !pready;
        prev_paddr = paddr;

        fifo_read = pop_once || (int'($urandom_range(99)) < pop_pct);
        pop_once  = 1'b0;
        start     = start_req || (stray_en && busy && $urandom_range(3) == 0);
        if (start && !start_req) addr_info = {$urandom, 4'($urandom), 3'($urandom), 2'($urandom)};
        if (fifo_read && mq.size() > 0) void'(mq.pop_front());
        if (complete) mq.push_back(ent);
        @(negedge clk);
    endtask

    task automatic begin_burst(input logic [31:0] a, input int len, input int size, input logic [1:0] b);
        beats = len + 1;
        beat_idx = 0;
        acc_cycles = 0;
        wait_total = 0;
        psel_cycles = 0;
        done_cnt = 0;
        obs_addr.delete();
        for (int i = 0; i < 16; i++) exp_addr[i] = ref_addr(a, len, size, b, i);
        chk("idle_before_start", 64'(busy), 64'(0));
        addr_info = {a, 4'(len), 3'(size), b};
        start_req = 1'b1;
        step();
        start_req = 1'b0;
    endtask

    task automatic finish_burst(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        chk("done_within_budget", 64'(done_cnt > 0), 64'(1));
        chk("done_once", 64'(done_cnt), 64'(1));
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("done_single_cycle", 64'(done), 64'(0));
        chk("beats_executed", 64'(beat_idx), 64'(beats));
        chk("psel_cycles", 64'(psel_cycles), 64'(2 * beats + wait_total));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        pop_pct = 100;
        while (mq.size() > 0 && n < budget) begin
            step();
            n++;
        end
        pop_pct = 0;
        step();
        chk("drained", 64'(fifo_empty), 64'(1));
    endtask

    vec_t vt[7];
    int   wl[4] = '{1, 3, 7, 15};

    initial begin
        for (int i = 0; i < 16; i++) begin
            waits[i] = 0;
            errs[i] = 1'b0;
        end
        pop_pct = 0; pop_once = 0; start_req = 0; stray_en = 0;
        prev_setup = 0; prev_wait = 0; prev_paddr = '0;
        beats = 0; beat_idx = 0; done_cnt = 0;

        vt[0] = '{32'h1000,     4'd0, 3'd2, BURST_INCR,  -1, 0, -1, {32'h0,    32'h0,    32'h0,    32'h1000}};
        vt[1] = '{32'h2000,     4'd3, 3'd2, BURST_INCR,  -1, 0, -1, {32'h200C, 32'h2008, 32'h2004, 32'h2000}};
        vt[2] = '{32'h300C,     4'd3, 3'd2, BURST_WRAP,  -1, 0, -1, {32'h3008, 32'h3004, 32'h3000, 32'h300C}};
        vt[3] = '{32'h40,       4'd2, 3'd2, BURST_FIXED, -1, 0, -1, {32'h0,    32'h40,   32'h40,   32'h40}};
        vt[4] = '{32'h5000,     4'd3, 3'd2, BURST_INCR,   1, 3,  2, {32'h500C, 32'h5008, 32'h5004, 32'h5000}};
        vt[5] = '{32'hFFFFFFFC, 4'd2, 3'd2, BURST_INCR,  -1, 0, -1, {32'h0,    32'h4,    32'h0,    32'hFFFFFFFC}};
        vt[6] = '{32'h7000,     4'd1, 3'd0, 2'b11,       -1, 0, -1, {32'h0,    32'h0,    32'h7001, 32'h7000}};

        #3;
        chk("rst_psel", 64'(psel), 64'(0));
        chk("rst_penable", 64'(penable), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_paddr", 64'(paddr), 64'(0));
        chk("rst_empty", 64'(fifo_empty), 64'(1));
        chk("rst_count", 64'(fifo_count), 64'(0));
        chk("rst_data", 64'({fifo_data, fifo_resp}), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 16; i++) begin
                waits[i] = (i == vt[v].wait_beat) ? vt[v].wait_n : 0;
                errs[i]  = (i == vt[v].err_beat);
            end
            stray_en = 1'b1;
            begin_burst(vt[v].addr, int'(vt[v].len), int'(vt[v].size), vt[v].burst);
            finish_burst(60);
            for (int i = 0; i <= int'(vt[v].len); i++) begin
                if (i < obs_addr.size()) chk("tbl_paddr", 64'(obs_addr[i]), 64'(vt[v].exp_a[i*32 +: 32]));
            end
            drain(20);
        end

        for (int i = 0; i < 16; i++) begin
            waits[i] = 0;
            errs[i] = 1'b0;
        end
        stray_en = 1'b0;
        begin_burst(32'h8000, 7, 2, BURST_INCR);
        for (int n = 0; beat_idx < DEPTH && n < 40; n++) step();
        repeat (6) step();
        chk("bp_beats_held", 64'(beat_idx), 64'(DEPTH));
        chk("bp_busy", 64'(busy), 64'(1));
        chk("bp_psel_low", 64'(psel), 64'(0));
        pop_once = 1'b1;
        step();
        repeat (8) step();
        chk("bp_one_more", 64'(beat_idx), 64'(DEPTH + 1));
        pop_pct = 50;
        finish_burst(200);
        drain(40);

        waits[2] = 1000;
        begin_burst(32'h9000, 3, 2, BURST_INCR);
        for (int n = 0; !(beat_idx == 2 && psel && penable) && n < 20; n++) step();
        chk("rst_seq_in_access", 64'(beat_idx == 2 && psel && penable), 64'(1));
        chk("rst_seq_queued", 64'(fifo_count), 64'(2));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_psel", 64'(psel), 64'(0));
        chk("mid_rst_penable", 64'(penable), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_empty", 64'(fifo_empty), 64'(1));
        chk("mid_rst_count", 64'(fifo_count), 64'(0));
        mq.delete();
        prev_setup = 0; prev_wait = 0; pready = 0; fifo_read = 0; start = 0;
        waits[2] = 0;
        @(negedge clk);
        rst = 1'b0;
        begin_burst(32'hA000, 1, 2, BURST_INCR);
        finish_burst(30);
        if (obs_addr.size() == 2) begin
            chk("post_rst_a0", 64'(obs_addr[0]), 64'(32'hA000));
            chk("post_rst_a1", 64'(obs_addr[1]), 64'(32'hA004));
        end else begin
            chk("post_rst_beats", 64'(obs_addr.size()), 64'(2));
        end
        drain(20);

        for (int r = 0; r < 25; r++) begin
            logic [1:0]  b;
            int          len, size;
            logic [31:0] a;
            b    = 2'($urandom_range(3));
            len  = (b == BURST_WRAP) ? wl[$urandom_range(3)] : int'($urandom_range(15));
            size = int'($urandom_range(2));
            a    = $urandom;
            for (int i = 0; i < 16; i++) begin
                waits[i] = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
                errs[i]  = ($urandom_range(3) == 0);
            end
            pop_pct  = int'($urandom_range(90, 20));
            stray_en = 1'b1;
            begin_burst(a, len, size, b);
            finish_burst(400);
            drain(40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
